// File: rtl/ac97_pkg.sv
// Shared constants and types for the AC'97 SDATA_IN receive path.
// Frame geometry, capture indices, tag field positions and aligner state.
package ac97_pkg;
  localparam int FRAME_BITS = 256;
  localparam int SLOT0_BITS = 16;
  localparam int SLOT_BITS  = 20;

  localparam logic [7:0] TAG_END = 8'd15;
  localparam logic [7:0] S1_END  = 8'd35;
  localparam logic [7:0] S2_END  = 8'd55;
  localparam logic [7:0] S3_END  = 8'd75;
  localparam logic [7:0] S4_END  = 8'd95;

  localparam int TAG_READY   = 15;
  localparam int TAG_SLOT_HI = 14;
  localparam int TAG_SLOT_LO = 3;

  typedef enum logic {HUNT, LOCK} align_state_e;

  // Slot n valid is tag bit 15-n, which lands in SLOT_VALID[12-n].
  function automatic logic slot_ok(input logic [11:0] sv, input logic [3:0] n);
    return sv[4'd12 - n];
  endfunction
endpackage

// File: rtl/ac97_frame_aligner.sv
// SYNC edge detect, frame bit counter and HUNT/LOCK tracking.
// frame_err is a registered 1-cycle pulse; drop marks the cycle lock is lost.
module ac97_frame_aligner
  import ac97_pkg::*;
#(
  parameter int SYNC_LAG = 1
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       sync,
  output logic       locked,
  output logic [7:0] bit_cnt,
  output logic       frame_err,
  output logic       drop
);
  localparam logic [7:0] L    = 8'((FRAME_BITS - SYNC_LAG) % FRAME_BITS);
  localparam logic [7:0] L_M1 = L - 8'd1;

  align_state_e state_q, state_d;
  logic sync_q, fs, at_end, err_d;

  assign fs     = sync & ~sync_q;
  assign at_end = (bit_cnt == L_M1);
  assign locked = (state_q == LOCK);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    drop    = 1'b0;
    case (state_q)
      HUNT: if (fs) state_d = LOCK;
      LOCK: begin
        if (fs) err_d = ~at_end;
        else if (at_end) begin
          err_d   = 1'b1;
          drop    = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q   <= HUNT;
      sync_q    <= 1'b0;
      bit_cnt   <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync;
      bit_cnt   <= fs ? L : bit_cnt + 8'd1;
      frame_err <= err_d;
    end
  end
endmodule

// File: rtl/ac97_sdata_in_deframer.sv
// AC'97 SDATA_IN deframer: deserialises each frame, decodes the tag and
// publishes codec status readback (slots 1/2) and record PCM (slots 3/4).
module ac97_sdata_in_deframer
  import ac97_pkg::*;
#(
  parameter int SAMPLE_W = 18,
  parameter int SYNC_LAG = 1
) (
  input  logic                BIT_CLK,
  input  logic                SYSTEM_RESET_N,
  input  logic                SYNC,
  input  logic                SDATA_IN,
  output logic                LOCKED,
  output logic                CODEC_READY,
  output logic [11:0]         SLOT_VALID,
  output logic [6:0]          STATUS_ADDR,
  output logic [15:0]         STATUS_DATA,
  output logic                STATUS_VALID,
  output logic [SAMPLE_W-1:0] PCM_L_IN,
  output logic [SAMPLE_W-1:0] PCM_R_IN,
  output logic                PCM_VALID,
  output logic                FRAME_ERR
);
  logic [SLOT_BITS-2:0] shreg;
  logic [SLOT_BITS-1:0] w, left_hold;
  logic [6:0]           addr_hold;
  logic [7:0]           bit_cnt;
  logic                 drop, status_ok, pcm_ok;

  assign w = {shreg, SDATA_IN};

  ac97_frame_aligner #(.SYNC_LAG(SYNC_LAG)) u_align (
    .gclk      (BIT_CLK),
    .grst_n    (SYSTEM_RESET_N),
    .sync      (SYNC),
    .locked    (LOCKED),
    .bit_cnt   (bit_cnt),
    .frame_err (FRAME_ERR),
    .drop      (drop)
  );

  assign status_ok = CODEC_READY & slot_ok(SLOT_VALID, 4'd1) & slot_ok(SLOT_VALID, 4'd2);
  assign pcm_ok    = CODEC_READY & slot_ok(SLOT_VALID, 4'd3) & slot_ok(SLOT_VALID, 4'd4);

  always_ff @(posedge BIT_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      shreg        <= '0;
      addr_hold    <= '0;
      left_hold    <= '0;
      CODEC_READY  <= 1'b0;
      SLOT_VALID   <= '0;
      STATUS_ADDR  <= '0;
      STATUS_DATA  <= '0;
      STATUS_VALID <= 1'b0;
      PCM_L_IN     <= '0;
      PCM_R_IN     <= '0;
      PCM_VALID    <= 1'b0;
    end else begin
      shreg        <= w[SLOT_BITS-2:0];
      STATUS_VALID <= 1'b0;
      PCM_VALID    <= 1'b0;
      if (drop) CODEC_READY <= 1'b0;
      // Decode only while locked; bit_cnt indexes the bit entering w this edge.
      if (LOCKED) begin
        case (bit_cnt)
          TAG_END: begin
            CODEC_READY <= w[TAG_READY];
            SLOT_VALID  <= w[TAG_SLOT_HI:TAG_SLOT_LO];
          end
          S1_END: addr_hold <= w[18:12];
          S2_END: if (status_ok) begin
            STATUS_ADDR  <= addr_hold;
            STATUS_DATA  <= w[19:4];
            STATUS_VALID <= 1'b1;
          end
          S3_END: left_hold <= w;
          S4_END: if (pcm_ok) begin
            PCM_L_IN  <= left_hold[SLOT_BITS-1 -: SAMPLE_W];
            PCM_R_IN  <= w[SLOT_BITS-1 -: SAMPLE_W];
            PCM_VALID <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
